ddr2_host_cmd_issuer: RTL and testbench
=======================================

Name: ddr2_host_cmd_issuer

Overview:
Host-side front end that sits directly upstream of ddr2_controller and drives its CMD/SZ/OP/DIN/ADDR input port.
- Accepts one request at a time from a host valid/ready interface, plus a separate write-data stream.
- Expands block writes into per-word controller entries and applies FIFO-space admission control.
- Drains the controller's read-return path (VALIDOUT/DOUT/RADDR) through FETCHING.
- Tracks outstanding read words so the host knows when the memory system is quiescent.

Parameters:
FIFO_DEPTH, 64, controller command-FIFO depth in entries; FILLCOUNT is compared against this.
MAX_OUTSTANDING, 64, maximum read words in flight; further reads are blocked at this limit.
OCNT_W, 7, width of the outstanding-read counter (must satisfy 2^OCNT_W > MAX_OUTSTANDING).

Ports:
clk  in  1  system clock (500 MHz)
reset  in  1  asynchronous, active-high reset
req_valid  in  1  host request valid
req_ready  out  1  request accepted when req_valid & req_ready at posedge clk
req_cmd  in  3  000 NOP, 001 SCR, 010 SCW, 011 BLR, 100 BLW, 101 ATR, 110 ATW, 111 NOP
req_sz  in  2  block size; words = 8*(req_sz+1)
req_op  in  3  atomic op code, passed through unchanged
req_addr  in  25  word address
wdata_valid  in  1  host write word valid
wdata_ready  out  1  write word consumed when wdata_valid & wdata_ready
wdata  in  16  host write word
notfull  in  1  controller FIFO can accept an entry this cycle
fillcount  in  7  controller FIFO occupancy
cmd  out  3  to controller; NOP (000) means no push
sz  out  2  to controller
op  out  3  to controller
din  out  16  to controller
addr  out  25  to controller
validout  in  1  controller read-return word valid
dout  in  16  controller read data
raddr  in  25  controller read address
fetching  out  1  pop strobe to the controller return path
rsp_valid  out  1  read word valid to host
rsp_ready  in  1  host accepts read word
rsp_data  out  16  read data to host
rsp_addr  out  25  read address to host
busy  out  1  high when state != IDLE or the outstanding count != 0

Behaviour:
- Reset (asynchronous) values: state=IDLE; cmd=000; sz, op, din, addr=0; req_ready=0; wdata_ready=0; outstanding=0; busy=0. Reset mid-burst abandons the burst with no further pushes; the host must re-issue.
- A controller push occurs on any cycle where the registered cmd != 000. Pushes are issued only when notfull=1 on the preceding cycle. cmd, sz, op, din and addr are registered outputs.
- Entry count N per request: SCR, SCW, ATR, ATW = 1. BLR = 1 (single command entry; 8*(sz+1) read words are returned). BLW = 8*(sz+1) entries.
- Read-word count R: SCR, ATR = 1; BLR = 8*(sz+1); all other commands = 0.
- IDLE:
  - req_ready=1.
  - On accept, latch the request and go to CHECK.
  - req_cmd NOP (000 or 111) is accepted and dropped; state stays IDLE.
- CHECK (admission):
  - Proceed when fillcount + N <= FIFO_DEPTH and outstanding + R <= MAX_OUTSTANDING. Otherwise stay in CHECK (no timeout).
  - Writes (SCW, ATW, BLW) proceed to WR_BURST. All other commands proceed to ISSUE.
- ISSUE: push one entry with the latched addr and din=0. Add R to outstanding. Return to IDLE.
- WR_BURST:
  - wdata_ready=1 only when notfull=1.
  - Each consumed word pushes one entry: first word at addr = req_addr, then addr+1, +2, ... The 25-bit addition wraps modulo 2^25.
  - For BLW, sz stays constant across all entries. For SCW and ATW, N=1.
  - If notfull or wdata_valid drops, cmd=NOP that cycle and the burst resumes with no skipped or repeated addresses.
  - After the N-th word, go to IDLE. A read-return pop and a push in the same cycle are independent.
- Read return (combinational):
  - rsp_valid = validout; rsp_data = dout; rsp_addr = raddr.
  - fetching = validout & rsp_ready.
  - Each fetching cycle decrements outstanding by 1.
  - An increment by R and a decrement in the same cycle net to outstanding + R - 1.
  - A decrement while outstanding = 0 saturates at 0 (protocol error; the counter does not underflow).
- busy falls the cycle after the last read word is fetched while in IDLE.

Test Plan:
- Reset, then SCR to addr 0x0000010 with fillcount=0 and notfull=1 -> one cycle of cmd=001, addr=0x0000010; outstanding goes 0->1; after validout&rsp_ready, outstanding=0 and busy=0.
- BLW sz=01, addr 0x1FFFFFE, 16 data words 0xA000..0xA00F streamed without gaps -> 16 pushes of cmd=100 with addr wrapping 0x1FFFFFE, 0x1FFFFFF, 0x0000000..0x000000D; din matches in order.
- Same BLW with notfull forced low for 3 cycles after word 5 -> cmd=000 for those cycles, wdata_ready=0, and word 6 goes to the next address with no gaps or repeats.
- fillcount=60 with BLW sz=00 (N=8) -> remains in CHECK and req_ready=0; drop fillcount to 56 -> burst starts the next cycle.
- Four BLR sz=11 (32 words each) with no rsp_ready -> two accepted (outstanding=64); the third stalls in CHECK until at least 32 words are fetched.
- Assert reset during word 4 of a BLW -> all outputs reach their reset values immediately; no further pushes occur; a new SCR after deassertion is issued normally.

Source files
------------

// File: rtl/ddr2_host_cmd_issuer.sv
// Host-side command issuer for ddr2_controller: admits one request at a time,
// expands block writes into per-word pushes and tracks outstanding read words.
`timescale 1ns/1ps
module ddr2_host_cmd_issuer #(
    parameter int FIFO_DEPTH      = 64,
    parameter int MAX_OUTSTANDING = 64,
    parameter int OCNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_cmd,
    input  logic [1:0]  req_sz,
    input  logic [2:0]  req_op,
    input  logic [24:0] req_addr,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [15:0] wdata,
    input  logic        notfull,
    input  logic [6:0]  fillcount,
    output logic [2:0]  cmd,
    output logic [1:0]  sz,
    output logic [2:0]  op,
    output logic [15:0] din,
    output logic [24:0] addr,
    input  logic        validout,
    input  logic [15:0] dout,
    input  logic [24:0] raddr,
    output logic        fetching,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [24:0] rsp_addr,
    output logic        busy
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WR
    } state_t;

    localparam logic [2:0] C_NOP  = 3'b000;
    localparam logic [2:0] C_SCR  = 3'b001;
    localparam logic [2:0] C_SCW  = 3'b010;
    localparam logic [2:0] C_BLR  = 3'b011;
    localparam logic [2:0] C_BLW  = 3'b100;
    localparam logic [2:0] C_ATR  = 3'b101;
    localparam logic [2:0] C_ATW  = 3'b110;
    localparam logic [2:0] C_NOP7 = 3'b111;

    localparam logic [15:0] LP_FDEPTH = 16'(FIFO_DEPTH);
    localparam logic [15:0] LP_OMAX   = 16'(MAX_OUTSTANDING);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_lcmd;
    logic [1:0]        r_lsz;
    logic [2:0]        r_lop;
    logic [24:0]       r_laddr;
    logic [5:0]        r_left;
    logic [OCNT_W-1:0] r_out;
    logic [OCNT_W-1:0] w_out_nxt;
    logic [2:0]        r_cmd;
    logic [1:0]        r_sz;
    logic [2:0]        r_op;
    logic [15:0]       r_din;
    logic [24:0]       r_addr;

    logic [2:0]  w_blk;
    logic [5:0]  w_words;
    logic [5:0]  w_n;
    logic [5:0]  w_r;
    logic [5:0]  w_inc;
    logic [15:0] w_fill_sum;
    logic [15:0] w_out_sum;
    logic        w_adm_ok;
    logic        w_is_wr;
    logic        w_fetch;
    logic        w_accept;
    logic        w_push;
    logic        w_consume;
    logic [15:0] w_pdin;

    assign w_blk   = 3'({1'b0, r_lsz} + 3'd1);
    assign w_words = {w_blk, 3'b000};
    assign w_is_wr = (r_lcmd == C_SCW) || (r_lcmd == C_ATW) ||
                     (r_lcmd == C_BLW);

    // Entries pushed (N) and read words returned (R) for the latched request
    always_comb begin
        w_n = 6'd1;
        w_r = 6'd0;
        unique case (1'b1)
            (r_lcmd == C_BLW): w_n = w_words;
            (r_lcmd == C_BLR): w_r = w_words;
            (r_lcmd == C_SCR),
            (r_lcmd == C_ATR): w_r = 6'd1;
            default: ;
        endcase
    end

    assign w_fill_sum = 16'(fillcount) + 16'(w_n);
    assign w_out_sum  = 16'(r_out) + 16'(w_r);
    assign w_adm_ok   = (w_fill_sum <= LP_FDEPTH) && (w_out_sum <= LP_OMAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        w_consume   = 1'b0;
        w_pdin      = 16'd0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (req_cmd != C_NOP && req_cmd != C_NOP7)
                        w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_adm_ok) w_state_nxt = w_is_wr ? S_WR : S_ISSUE;
            end
            S_ISSUE: begin
                if (notfull) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR: begin
                if (notfull && wdata_valid) begin
                    w_push    = 1'b1;
                    w_consume = 1'b1;
                    w_pdin    = wdata;
                    if (r_left == 6'd1) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_fetch = validout & rsp_ready;
    assign w_inc   = (r_state == S_ISSUE && notfull) ? w_r : 6'd0;

    // Read-return pops saturate at zero when nothing is outstanding
    always_comb begin
        w_out_nxt = r_out;
        if (w_inc != 6'd0)
            w_out_nxt = r_out + OCNT_W'(w_inc) - OCNT_W'(w_fetch);
        else if (w_fetch && r_out != '0)
            w_out_nxt = r_out - OCNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lcmd  <= C_NOP;
            r_lsz   <= 2'd0;
            r_lop   <= 3'd0;
            r_laddr <= 25'd0;
            r_left  <= 6'd0;
            r_out   <= '0;
            r_cmd   <= C_NOP;
            r_sz    <= 2'd0;
            r_op    <= 3'd0;
            r_din   <= 16'd0;
            r_addr  <= 25'd0;
        end else begin
            r_out <= w_out_nxt;
            if (w_accept) begin
                r_lcmd  <= req_cmd;
                r_lsz   <= req_sz;
                r_lop   <= req_op;
                r_laddr <= req_addr;
            end
            if (r_state == S_CHECK && w_state_nxt == S_WR) r_left <= w_n;
            if (w_consume) begin
                r_laddr <= r_laddr + 25'd1;
                r_left  <= r_left - 6'd1;
            end
            r_cmd <= w_push ? r_lcmd : C_NOP;
            if (w_push) begin
                r_sz   <= r_lsz;
                r_op   <= r_lop;
                r_din  <= w_pdin;
                r_addr <= r_laddr;
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE) && !reset;
    assign wdata_ready = (r_state == S_WR) && notfull;
    assign cmd         = r_cmd;
    assign sz          = r_sz;
    assign op          = r_op;
    assign din         = r_din;
    assign addr        = r_addr;
    assign fetching    = w_fetch;
    assign rsp_valid   = validout;
    assign rsp_data    = dout;
    assign rsp_addr    = raddr;
    assign busy        = (r_state != S_IDLE) || (r_out != '0);
endmodule

// File: tb/tb_ddr2_host_cmd_issuer.sv
// Bench for ddr2_host_cmd_issuer: directed scenarios plus random traffic
// against a transaction-level model of expected pushes and outstanding reads.
`timescale 1ns/1ps
module tb_ddr2_host_cmd_issuer;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [2:0]  req_cmd;
    logic [1:0]  req_sz;
    logic [2:0]  req_op;
    logic [24:0] req_addr;
    logic        wdata_valid, wdata_ready;
    logic [15:0] wdata;
    logic        notfull;
    logic [6:0]  fillcount;
    logic [2:0]  cmd;
    logic [1:0]  sz;
    logic [2:0]  op;
    logic [15:0] din;
    logic [24:0] addr;
    logic        validout;
    logic [15:0] dout;
    logic [24:0] raddr;
    logic        fetching, rsp_valid, rsp_ready, busy;
    logic [15:0] rsp_data;
    logic [24:0] rsp_addr;

    ddr2_host_cmd_issuer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_sz(req_sz), .req_op(req_op),
        .req_addr(req_addr),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .wdata(wdata), .notfull(notfull), .fillcount(fillcount),
        .cmd(cmd), .sz(sz), .op(op), .din(din), .addr(addr),
        .validout(validout), .dout(dout), .raddr(raddr),
        .fetching(fetching), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  c;
        logic [1:0]  s;
        logic [2:0]  o;
        logic [24:0] a;
    } req_t;
    typedef struct packed {
        logic [2:0]  c;
        logic [1:0]  s;
        logic [2:0]  o;
        logic [15:0] d;
        logic [24:0] a;
    } push_t;

    req_t        rq[$];
    push_t       exp_q[$];
    logic [15:0] wmem [0:4095];
    int          wr_idx, rd_idx, m_wptr;
    int          total, bad, model_out, n_push;
    bit          inflight, acc_pend, prev_nf, prev_fetch;
    bit          r_hs, w_hs, mon_en, mode_rand;
    req_t        acc_req;
    logic        c_nf, c_vo, c_rr;
    logic [6:0]  c_fill;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic int n_words(input logic [1:0] s);
        return 8 * (int'(s) + 1);
    endfunction

    function automatic int n_reads(input logic [2:0] c, input logic [1:0] s);
        if (c == 3'd1 || c == 3'd5) return 1;
        if (c == 3'd3) return n_words(s);
        return 0;
    endfunction

    function automatic bit is_wr(input logic [2:0] c);
        return c == 3'd2 || c == 3'd4 || c == 3'd6;
    endfunction

    function automatic int n_entries(input logic [2:0] c, input logic [1:0] s);
        if (c == 3'd0 || c == 3'd7) return 0;
        if (c == 3'd4) return n_words(s);
        return 1;
    endfunction

    task automatic add_req(input logic [2:0] c, input logic [1:0] s,
                           input logic [2:0] o, input logic [24:0] a,
                           input int wbase);
        req_t q;
        q.c = c; q.s = s; q.o = o; q.a = a;
        rq.push_back(q);
        if (is_wr(c))
            for (int i = 0; i < n_entries(c, s); i++) begin
                wmem[wr_idx] = (wbase >= 0) ? 16'(wbase + i) : 16'($urandom);
                wr_idx++;
            end
    endtask

    task automatic build_exp(input req_t q);
        push_t p;
        int n;
        n = n_entries(q.c, q.s);
        for (int i = 0; i < n; i++) begin
            p.c = q.c; p.s = q.s; p.o = q.o;
            p.a = 25'(q.a + 25'(i));
            p.d = 16'd0;
            if (is_wr(q.c)) begin
                p.d = wmem[m_wptr];
                m_wptr++;
            end
            exp_q.push_back(p);
        end
        if (n > 0) inflight = 1'b1;
    endtask

    task automatic model_clear();
        rq.delete();
        exp_q.delete();
        rd_idx = wr_idx; m_wptr = wr_idx;
        inflight = 0; acc_pend = 0; model_out = 0;
        r_hs = 0; w_hs = 0; prev_nf = 0; prev_fetch = 0;
        req_valid = 0; wdata_valid = 0;
    endtask

    task automatic drive();
        if (w_hs) rd_idx++;
        if (r_hs) begin
            void'(rq.pop_front());
            req_valid = 1'b0;
        end else if (!req_valid && rq.size() > 0 &&
                     (!mode_rand || $urandom_range(0, 1) == 1)) begin
            req_valid = 1'b1;
            req_cmd = rq[0].c; req_sz = rq[0].s;
            req_op = rq[0].o; req_addr = rq[0].a;
        end
        r_hs = 0; w_hs = 0;
        wdata_valid = (rd_idx < wr_idx) &&
                      (!mode_rand || $urandom_range(0, 3) != 0);
        wdata = wmem[rd_idx];
        if (mode_rand) begin
            notfull   = ($urandom_range(0, 7) != 0);
            fillcount = 7'($urandom_range(0, 64));
            validout  = 1'($urandom_range(0, 1));
            rsp_ready = 1'($urandom_range(0, 1));
        end else begin
            notfull = c_nf; fillcount = c_fill;
            validout = c_vo; rsp_ready = c_rr;
        end
        dout  = 16'($urandom);
        raddr = 25'($urandom);
    endtask

    task automatic monitor();
        push_t p;
        int r;
        if (acc_pend) begin
            acc_pend = 0;
            build_exp(acc_req);
        end
        chk("fetching", fetching, validout & rsp_ready);
        chk("rsp_valid", rsp_valid, validout);
        chk("rsp_data", rsp_data, dout);
        chk("rsp_addr", rsp_addr, raddr);
        r = 0;
        if (cmd != 3'b000) begin
            n_push++;
            chk("push_nf", prev_nf, 1);
            if (exp_q.size() == 0) chk("push_unexp", cmd, 0);
            else begin
                p = exp_q.pop_front();
                chk("cmd", cmd, p.c);
                chk("sz", sz, p.s);
                chk("op", op, p.o);
                chk("din", din, p.d);
                chk("addr", addr, p.a);
                r = n_reads(cmd, sz);
                if (r > 0) chk("rd_limit", (model_out + r) <= 64, 1);
                if (exp_q.size() == 0) inflight = 0;
            end
        end
        model_out += r;
        if (prev_fetch && model_out > 0) model_out--;
        chk("busy", busy, (model_out != 0) || inflight);
        chk("req_ready", req_ready, !inflight);
        if (wdata_ready) chk("wrdy_nf", notfull, 1);
        prev_nf = notfull;
        prev_fetch = validout & rsp_ready;
        r_hs = req_valid & req_ready;
        if (r_hs) begin
            acc_pend = 1;
            acc_req.c = req_cmd; acc_req.s = req_sz;
            acc_req.o = req_op; acc_req.a = req_addr;
        end
        w_hs = wdata_valid & wdata_ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        if (mon_en) monitor();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while ((rq.size() > 0 || req_valid || acc_pend || inflight) &&
               k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, k < budget, 1);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        c_vo = 1; c_rr = 1;
        while (model_out > 0 && k < 500) begin
            tick();
            k++;
        end
        c_vo = 0; c_rr = 0;
        tick();
        chk({tag, "_drain"}, busy, 0);
    endtask

    task automatic chk_reset_outs();
        chk("rst_cmd", cmd, 0);
        chk("rst_sz", sz, 0);
        chk("rst_op", op, 0);
        chk("rst_din", din, 0);
        chk("rst_addr", addr, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_wdata_ready", wdata_ready, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1;
    endtask

    initial begin
        int n0, k;
        total = 0; bad = 0; n_push = 0;
        wr_idx = 0; mon_en = 0; mode_rand = 0;
        c_nf = 1; c_fill = 0; c_vo = 0; c_rr = 0;
        reset = 1'b1;
        req_cmd = 0; req_sz = 0; req_op = 0; req_addr = 0; wdata = 0;
        notfull = 1; fillcount = 0; validout = 0; rsp_ready = 0;
        dout = 0; raddr = 0;
        model_clear();
        repeat (3) tick();
        chk_reset_outs();
        release_reset();

        // single read, then drain it
        add_req(3'd1, 2'd0, 3'd0, 25'h0000010, -1);
        wait_done("scr", 50);
        chk("scr_busy", busy, 1);
        c_vo = 1; c_rr = 1;
        tick();
        c_vo = 0; c_rr = 0;
        tick();
        chk("scr_idle", busy, 0);

        // block write wrapping past the top of the address space
        n0 = n_push;
        add_req(3'd4, 2'd1, 3'd3, 25'h1FFFFFE, 16'hA000);
        wait_done("blw", 100);
        chk("blw_cnt", n_push - n0, 16);

        // same burst with notfull dropped for three cycles
        n0 = n_push;
        add_req(3'd4, 2'd1, 3'd3, 25'h1FFFFFE, 16'hA000);
        k = 0;
        while (n_push - n0 < 5 && k < 100) begin
            tick();
            k++;
        end
        chk("nf_reach5", k < 100, 1);
        c_nf = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nf_wrdy", wdata_ready, 0);
            if (i > 0) chk("nf_cmd", cmd, 0);
        end
        c_nf = 1;
        tick();
        chk("nf_cmd_last", cmd, 0);
        wait_done("nf", 100);
        chk("nf_cnt", n_push - n0, 16);

        // FIFO-space admission
        c_fill = 7'd60;
        n0 = n_push;
        add_req(3'd4, 2'd0, 3'd1, 25'h0001000, -1);
        repeat (8) tick();
        chk("fc_hold", n_push - n0, 0);
        chk("fc_rrdy", req_ready, 0);
        chk("fc_wrdy", wdata_ready, 0);
        c_fill = 7'd56;
        tick();
        tick();
        chk("fc_go", wdata_ready, 1);
        wait_done("fc", 100);
        chk("fc_cnt", n_push - n0, 8);
        c_fill = 0;

        // outstanding-read limit
        n0 = n_push;
        for (int i = 0; i < 4; i++)
            add_req(3'd3, 2'd3, 3'd0, 25'(32'h2000 + i * 32), -1);
        repeat (30) tick();
        chk("blr_two", n_push - n0, 2);
        chk("blr_rrdy", req_ready, 0);
        c_vo = 1; c_rr = 1;
        repeat (31) tick();
        c_vo = 0; c_rr = 0;
        repeat (6) tick();
        chk("blr_stall", n_push - n0, 2);
        c_vo = 1; c_rr = 1;
        tick();
        c_vo = 0; c_rr = 0;
        repeat (6) tick();
        chk("blr_third", n_push - n0, 3);
        c_vo = 1; c_rr = 1;
        wait_done("blr", 400);
        drain("blr");

        // random traffic
        mode_rand = 1;
        for (int i = 0; i < 40; i++)
            add_req(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    3'($urandom), ($urandom_range(0, 3) == 0) ?
                    25'(25'h1FFFFF0 + 25'($urandom_range(0, 15))) :
                    25'($urandom), -1);
        wait_done("rand", 20000);
        mode_rand = 0;
        drain("rand");

        // reset in the middle of a block write
        c_nf = 1; c_fill = 0;
        n0 = n_push;
        add_req(3'd4, 2'd1, 3'd2, 25'h0003000, -1);
        k = 0;
        while (n_push - n0 < 3 && k < 100) begin
            tick();
            k++;
        end
        chk("mid_reach3", k < 100, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outs();
        mon_en = 0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_nopush", cmd, 0);
        end
        release_reset();
        n0 = n_push;
        add_req(3'd1, 2'd0, 3'd0, 25'h0000010, -1);
        wait_done("post_rst", 50);
        chk("post_rst_cnt", n_push - n0, 1);
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
